// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V load/store stage that splits accesses into 16-bit SRAM req/ack halves.
module load_store_unit #(
    parameter int ADDR_W = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [31:0]       inst,
    input  logic [31:0]       rs1,
    input  logic [31:0]       rs2,
    output logic              stall,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              misalign,
    output logic              mem_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_be_n,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;
    state_t state, state_n;
    logic is_ld, is_st, is_mem, legal, mis, go, tmo, word, half, ld_r, to_r, unused;
    logic [2:0] f3, f3_r;
    logic [31:0] imm, ea, wd_r, ext;
    logic [ADDR_W:0] ea_r;
    logic [ADDR_W-2:0] w;
    logic [15:0] hi_r, lo_r, cnt;
    logic [7:0] b;

    assign f3 = inst[14:12];
    assign is_ld = ex_valid && inst[6:0] == 7'b0000011;
    assign is_st = ex_valid && inst[6:0] == 7'b0100011;
    assign is_mem = is_ld || is_st;
    assign imm = is_st ? {{20{inst[31]}}, inst[31:25], inst[11:7]} : {{20{inst[31]}}, inst[31:20]};
    assign ea = rs1 + imm;
    assign legal = is_ld ? (f3 != 3'd3 && f3 < 3'd6) : f3 < 3'd3;
    assign mis = (f3[1:0] == 2'd1 && ea[0]) || (f3[1:0] == 2'd2 && ea[1:0] != 2'd0);
    assign go = is_mem && legal && !mis;
    assign unused = ^{ea[31:ADDR_W+1], inst[19:15]};

    assign word = f3_r[1:0] == 2'd2;
    assign half = f3_r[1:0] == 2'd1;
    assign w = ea_r[ADDR_W:2];
    assign tmo = (state == ACC0 || state == ACC1) && cnt == 16'(TIMEOUT);
    // Sub-word loads keep their half in hi_r; words put the upper half there.
    assign b = ea_r[0] ? hi_r[15:8] : hi_r[7:0];
    assign ext = word ? {hi_r, lo_r} :
                 half ? {{16{~f3_r[2] & hi_r[15]}}, hi_r} : {{24{~f3_r[2] & b[7]}}, b};
    assign mem_addr = mem_req ? {w, word ? state == ACC1 : ~ea_r[1]} : '0;
    assign mem_we = mem_req && !ld_r;
    assign mem_wdata = !mem_we ? 16'h0 :
                       word ? (state == ACC1 ? wd_r[15:0] : wd_r[31:16]) :
                       half ? wd_r[15:0] : {2{wd_r[7:0]}};
    assign mem_be_n = !mem_req ? 2'b11 : (word || half) ? 2'b00 : ea_r[0] ? 2'b01 : 2'b10;
    assign load_data = (load_valid && !to_r) ? ext : 32'h0;

    always_comb begin
        state_n = state;
        stall = 1'b0;
        mem_req = 1'b0;
        misalign = 1'b0;
        mem_err = 1'b0;
        load_valid = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    stall = go;
                    misalign = is_mem && legal && mis;
                    mem_err = is_mem && !legal;
                    state_n = go ? ACC0 : IDLE;
                end
                ACC0, ACC1: begin
                    stall = 1'b1;
                    mem_req = !tmo;
                    mem_err = tmo;
                    state_n = tmo ? DONE : !mem_ack ? state : (state == ACC0 && word) ? ACC1 : DONE;
                end
                default: begin
                    load_valid = ld_r;
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 16'd0;
            to_r <= 1'b0;
            ld_r <= 1'b0;
            f3_r <= 3'd0;
            ea_r <= '0;
            wd_r <= 32'h0;
            hi_r <= 16'h0;
            lo_r <= 16'h0;
        end else begin
            state <= state_n;
            cnt <= (state_n == state && (state == ACC0 || state == ACC1)) ? cnt + 16'd1 : 16'd0;
            if (state == IDLE && go) begin
                ea_r <= ea[ADDR_W:0];
                wd_r <= rs2;
                f3_r <= f3;
                ld_r <= is_ld;
                to_r <= 1'b0;
            end
            if (mem_req && mem_ack) begin
                if (state == ACC0) hi_r <= mem_rdata;
                else lo_r <= mem_rdata;
            end
            if (tmo) to_r <= 1'b1;
        end
    end
endmodule
